// File: rtl/system_bus_pkg.sv
// Shared definitions for the system bus master port: default field widths,
// the serial frame length and the port state encoding.
package system_bus_pkg;

    localparam int ADDR_WIDTH_DEF  = 12;
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int BURST_WIDTH_DEF = 13;

    // Largest of three widths; sets how many serial bits a request takes.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int MAX_W = max3(ADDR_WIDTH_DEF, DATA_WIDTH_DEF, BURST_WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2,
        RECV = 2'd3
    } state_t;

endpackage

// File: rtl/bus_master_port_if.sv
// Serial link between the bus master port and the slave: three request
// lines with their handshake, transaction enables, and the read-data return.
interface bus_master_port_if;

    logic tx_address;
    logic tx_data;
    logic tx_burst;
    logic master_valid;
    logic slave_ready;
    logic write_en;
    logic read_en;
    logic master_ready;
    logic slave_valid;
    logic rx_data;
    logic rx_done;

    modport master (
        output tx_address, tx_data, tx_burst, master_valid,
        output write_en, read_en, master_ready,
        input  slave_ready, slave_valid, rx_data, rx_done
    );

    modport slave (
        input  tx_address, tx_data, tx_burst, master_valid,
        input  write_en, read_en, master_ready,
        output slave_ready, slave_valid, rx_data, rx_done
    );

endinterface

// File: rtl/bus_piso.sv
// Parallel-in serial-out shifter for one request field. The current bit is
// always at position 0; zeros are shifted in from the top, so the line reads
// 0 once more bits than WIDTH have been requested.
module bus_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             bit_out
);

    logic [WIDTH-1:0] sreg;

    // Capture a new field on load, otherwise advance one bit per shift.
    // NOTE: reset is synchronous and active-low, so it lives inside the clocked
    // branch; state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= load_data;
        end else if (shift_en) begin
            sreg <= sreg >> 1;
        end
    end

    assign bit_out = sreg[0];

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial port of the system bus. Accepts one parallel request,
// shifts address/data/burst out LSB-first under master_valid/slave_ready,
// then waits for rx_done (write) or collects DATA_WIDTH read bits (read).
// Optional feature macro: MASTER_TIMEOUT_EN adds an inactivity timeout that
// aborts the transaction with an err pulse after TIMEOUT_CYCLES idle cycles.
module bus_master_port
    import system_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int BURST_WIDTH    = BURST_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    input  logic [BURST_WIDTH-1:0] req_burst,
    bus_master_port_if.master      bus,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   done,
    output logic                   err
);

    localparam int SER_BITS = max3(ADDR_WIDTH, DATA_WIDTH, BURST_WIDTH);
    localparam int CNT_W    = $clog2(SER_BITS + 1);
    localparam int RCNT_W   = $clog2(DATA_WIDTH + 1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RCNT_W-1:0]     rcnt_q, rcnt_d;
    logic [DATA_WIDTH-1:0] rx_buf_q, rx_buf_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic tx_address_q, tx_address_d;
    logic tx_data_q, tx_data_d;
    logic tx_burst_q, tx_burst_d;
    logic master_valid_q, master_valid_d;
    logic write_en_q, write_en_d;
    logic read_en_q, read_en_d;
    logic master_ready_q, master_ready_d;
    logic rd_valid_q, rd_valid_d;
    logic done_q, done_d;

    logic accept;
    logic shift_en;
    logic addr_bit, data_bit, burst_bit;

    assign req_ready = (state_q == IDLE) && reset;
    assign accept    = req_valid && req_ready;
    // A bit goes out on every SEND edge the slave is ready, until the frame is complete.
    assign shift_en  = (state_q == SEND) && bus.slave_ready && (cnt_q != CNT_W'(SER_BITS));

    bus_piso #(.WIDTH(ADDR_WIDTH)) u_addr_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (req_addr),
        .shift_en  (shift_en),
        .bit_out   (addr_bit)
    );

    // Reads carry no write data, so the data line is loaded with zeros.
    bus_piso #(.WIDTH(DATA_WIDTH)) u_data_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (req_write ? req_wdata : '0),
        .shift_en  (shift_en),
        .bit_out   (data_bit)
    );

    bus_piso #(.WIDTH(BURST_WIDTH)) u_burst_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (req_burst),
        .shift_en  (shift_en),
        .bit_out   (burst_bit)
    );

`ifdef MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             activity;
    logic             tmo_expire;
    logic             err_q;

    assign activity   = shift_en
                     || ((state_q == ACK)  && bus.rx_done)
                     || ((state_q == RECV) && bus.slave_valid);
    assign tmo_expire = (state_q != IDLE) && !activity
                     && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Inactivity counter: cleared outside transactions and on every handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_q <= '0;
        end else if ((state_q == IDLE) || activity || tmo_expire) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // One-cycle err pulse on the abort edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= tmo_expire;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state and next-output logic for the transaction sequencer.
    // NOTE: every _d signal is given a default before the case statement; a
    // branch that skipped one would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rcnt_d         = rcnt_q;
        rx_buf_d       = rx_buf_q;
        rd_data_d      = rd_data_q;
        tx_address_d   = tx_address_q;
        tx_data_d      = tx_data_q;
        tx_burst_d     = tx_burst_q;
        master_valid_d = 1'b0;
        write_en_d     = write_en_q;
        read_en_d      = read_en_q;
        master_ready_d = master_ready_q;
        rd_valid_d     = 1'b0;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SEND;
                    cnt_d      = '0;
                    write_en_d = req_write;
                    read_en_d  = !req_write;
                end
            end
            SEND: begin
                if (cnt_q == CNT_W'(SER_BITS)) begin
                    // Frame complete: park the lines low and wait for the slave.
                    state_d        = write_en_q ? ACK : RECV;
                    master_ready_d = !write_en_q;
                    rcnt_d         = '0;
                    tx_address_d   = 1'b0;
                    tx_data_d      = 1'b0;
                    tx_burst_d     = 1'b0;
                end else if (bus.slave_ready) begin
                    tx_address_d   = addr_bit;
                    tx_data_d      = data_bit;
                    tx_burst_d     = burst_bit;
                    master_valid_d = 1'b1;
                    cnt_d          = cnt_q + 1'b1;
                end
            end
            ACK: begin
                if (bus.rx_done) begin
                    done_d     = 1'b1;
                    write_en_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            RECV: begin
                if (bus.slave_valid) begin
                    // Shift in from the top so the first bit ends at bit 0.
                    rx_buf_d = {bus.rx_data, rx_buf_q[DATA_WIDTH-1:1]};
                    rcnt_d   = rcnt_q + 1'b1;
                    if (rcnt_q == RCNT_W'(DATA_WIDTH - 1)) begin
                        rd_data_d      = rx_buf_d;
                        rd_valid_d     = 1'b1;
                        done_d         = 1'b1;
                        read_en_d      = 1'b0;
                        master_ready_d = 1'b0;
                        state_d        = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef MASTER_TIMEOUT_EN
        if (tmo_expire) begin
            state_d        = IDLE;
            tx_address_d   = 1'b0;
            tx_data_d      = 1'b0;
            tx_burst_d     = 1'b0;
            master_valid_d = 1'b0;
            write_en_d     = 1'b0;
            read_en_d      = 1'b0;
            master_ready_d = 1'b0;
            rd_valid_d     = 1'b0;
            done_d         = 1'b0;
        end
`endif
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rcnt_q         <= '0;
            rx_buf_q       <= '0;
            rd_data_q      <= '0;
            tx_address_q   <= 1'b0;
            tx_data_q      <= 1'b0;
            tx_burst_q     <= 1'b0;
            master_valid_q <= 1'b0;
            write_en_q     <= 1'b0;
            read_en_q      <= 1'b0;
            master_ready_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rcnt_q         <= rcnt_d;
            rx_buf_q       <= rx_buf_d;
            rd_data_q      <= rd_data_d;
            tx_address_q   <= tx_address_d;
            tx_data_q      <= tx_data_d;
            tx_burst_q     <= tx_burst_d;
            master_valid_q <= master_valid_d;
            write_en_q     <= write_en_d;
            read_en_q      <= read_en_d;
            master_ready_q <= master_ready_d;
            rd_valid_q     <= rd_valid_d;
            done_q         <= done_d;
        end
    end

    assign bus.tx_address   = tx_address_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_burst     = tx_burst_q;
    assign bus.master_valid = master_valid_q;
    assign bus.write_en     = write_en_q;
    assign bus.read_en      = read_en_q;
    assign bus.master_ready = master_ready_q;
    assign rd_data          = rd_data_q;
    assign rd_valid         = rd_valid_q;
    assign done             = done_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: stimulus pushes the expected serial
// bits and completion events into queues; a monitor pops and compares them
// whenever the port presents master_valid or a done/rd_valid/err pulse.
module tb_bus_master_port;

`ifdef MASTER_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 256;
`endif
    localparam int NBITS = 13;

    typedef struct packed {
        logic a;
        logic d;
        logic b;
    } bits_t;

    typedef struct packed {
        logic       done;
        logic       rd_valid;
        logic       err;
        logic [7:0] rd;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic [12:0] req_burst;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;

    bus_master_port_if bus_if ();

    bus_master_port #(
        .ADDR_WIDTH     (12),
        .DATA_WIDTH     (8),
        .BURST_WIDTH    (13),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_burst (req_burst),
        .bus       (bus_if),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int    checks = 0;
    int    errors = 0;
    bits_t exp_bits[$];
    resp_t exp_resp[$];
    int    mv_first = -1;
    int    mv_last  = -1;
    int    acc_cyc  = 0;
    int    err_cyc  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {14'd0, req_ready, bus_if.tx_address, bus_if.tx_data, bus_if.tx_burst,
                bus_if.master_valid, bus_if.write_en, bus_if.read_en, bus_if.master_ready,
                rd_data, rd_valid, done, err};
    endfunction

    // Expected serial frame: each field LSB-first, zero past its width; reads send no data.
    task automatic push_bits(input logic wr, input logic [11:0] a, input logic [7:0] d,
                             input logic [12:0] b, input int n);
        bits_t e;
        for (int i = 0; i < n; i++) begin
            e.a = 1'(a >> i);
            e.d = wr ? 1'(d >> i) : 1'b0;
            e.b = 1'(b >> i);
            exp_bits.push_back(e);
        end
    endtask

    // Monitor: compare every valid serial bit and every completion pulse.
    initial begin
        bits_t e;
        resp_t r;
        forever begin
            @(posedge clk);
            #1;
            if (bus_if.master_valid) begin
                if (mv_first < 0) mv_first = cyc;
                mv_last = cyc;
                if (exp_bits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got %b%b%b expected none", bus_if.tx_address,
                             bus_if.tx_data, bus_if.tx_burst);
                end else begin
                    e = exp_bits.pop_front();
                    check("serial_bits", {29'd0, bus_if.tx_address, bus_if.tx_data, bus_if.tx_burst}, {29'd0, e});
                end
            end
            if (done || rd_valid || err) begin
                if (err) err_cyc = cyc;
                if (exp_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got done=%b rd_valid=%b err=%b expected none",
                             done, rd_valid, err);
                end else begin
                    r = exp_resp.pop_front();
                    check("completion_flags", {29'd0, done, rd_valid, err}, {29'd0, r.done, r.rd_valid, r.err});
                    if (r.rd_valid) check("rd_data", {24'd0, rd_data}, {24'd0, r.rd});
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [11:0] a, input logic [7:0] d,
                         input logic [12:0] b, input logic [7:0] rdata, input int n, input logic with_resp);
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        push_bits(wr, a, d, b, n);
        if (with_resp) exp_resp.push_back(wr ? resp_t'{1'b1, 1'b0, 1'b0, 8'h00} : resp_t'{1'b1, 1'b1, 1'b0, rdata});
        mv_first  = -1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_burst = b;
        req_valid = 1'b1;
        bus_if.slave_ready = 1'b0;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        check("req_ready_busy", {31'd0, req_ready}, 32'd0);
        check("enables_on_accept", {30'd0, bus_if.write_en, bus_if.read_en}, {30'd0, wr, !wr});
    endtask

    // Drive slave_ready per cycle (low for the stall window), optionally glitch rx_done.
    task automatic send(input int stall_first, input int stall_len, input int glitch);
        for (int c = 1; c <= NBITS + stall_len; c++) begin
            @(negedge clk);
            req_valid          = 1'b0;
            bus_if.slave_ready = !(c >= stall_first && c < stall_first + stall_len);
            bus_if.rx_done     = (c == glitch);
        end
        @(negedge clk);
        bus_if.slave_ready = 1'b0;
        bus_if.rx_done     = 1'b0;
        @(posedge clk);
        #1;
        check("first_bit_latency", mv_first, acc_cyc + 1);
        check("send_span", mv_last - mv_first + 1, NBITS + stall_len);
        check("mv_low_after_frame", {31'd0, bus_if.master_valid}, 32'd0);
        check("master_ready_after_frame", {31'd0, bus_if.master_ready}, {31'd0, bus_if.read_en});
    endtask

    task automatic ack();
        repeat (2) begin
            @(negedge clk);
            check("no_done_before_ack", {31'd0, done}, 32'd0);
        end
        bus_if.rx_done = 1'b1;
        @(posedge clk);
        #1;
        check("done_after_rx_done", {31'd0, done}, 32'd1);
        check("req_ready_after_ack", {31'd0, req_ready}, 32'd1);
        check("write_en_cleared", {31'd0, bus_if.write_en}, 32'd0);
        @(negedge clk);
        bus_if.rx_done = 1'b0;
    endtask

    task automatic recv(input logic [7:0] rdata, input int gap, input logic pend,
                        input logic [11:0] pa, input logic [7:0] pd, input logic [12:0] pb);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("req_ready_recv", {31'd0, req_ready}, 32'd0);
            if (i == 0 && pend) begin
                push_bits(1'b1, pa, pd, pb, NBITS);
                exp_resp.push_back(resp_t'{1'b1, 1'b0, 1'b0, 8'h00});
                mv_first  = -1;
                req_write = 1'b1;
                req_addr  = pa;
                req_wdata = pd;
                req_burst = pb;
                req_valid = 1'b1;
            end
            if (i == gap) begin
                bus_if.slave_valid = 1'b0;
                @(negedge clk);
            end
            bus_if.slave_valid = 1'b1;
            bus_if.rx_data     = rdata[i];
        end
        @(posedge clk);
        #1;
        check("read_en_cleared", {30'd0, bus_if.read_en, bus_if.master_ready}, 32'd0);
        check("req_ready_after_read", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        bus_if.slave_valid = 1'b0;
        bus_if.rx_data     = 1'b0;
        if (pend) begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            check("pending_accepted", {30'd0, req_ready, bus_if.write_en}, 32'd1);
        end
    endtask

    initial begin
        reset              = 1'b0;
        req_valid          = 1'b0;
        req_write          = 1'b0;
        req_addr           = '0;
        req_wdata          = '0;
        req_burst          = '0;
        bus_if.slave_ready = 1'b0;
        bus_if.slave_valid = 1'b0;
        bus_if.rx_data     = 1'b0;
        bus_if.rx_done     = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 32'd0);
        reset = 1'b1;

        // Write, slave always ready, early rx_done during SEND must be ignored.
        issue(1'b1, 12'hADD, 8'hBD, 13'h15AD, 8'h00, NBITS, 1'b1);
        send(0, 0, 5);
        ack();

        // Same write with slave_ready low for cycles 4-6.
        issue(1'b1, 12'hADD, 8'hBD, 13'h15AD, 8'h00, NBITS, 1'b1);
        send(4, 3, 0);
        ack();

        // Read 0x5A.
        issue(1'b0, 12'h123, 8'hFF, 13'h0F0F, 8'h5A, NBITS, 1'b1);
        send(0, 0, 0);
        recv(8'h5A, -1, 1'b0, 12'h000, 8'h00, 13'h0000);

        // A write in between must leave rd_data untouched.
        issue(1'b1, 12'h555, 8'h3C, 13'h1FFF, 8'h00, NBITS, 1'b1);
        send(0, 0, 0);
        ack();
        check("rd_data_hold", {24'd0, rd_data}, 32'h5A);

        // Read with a send stall, a slave_valid gap, and a request held during RECV.
        issue(1'b0, 12'hFED, 8'h00, 13'h0001, 8'hA5, NBITS, 1'b1);
        send(2, 1, 0);
        recv(8'hA5, 3, 1'b1, 12'h0F0, 8'h81, 13'h1000);
        send(0, 0, 0);
        ack();

        // Reset at SEND bit 5 aborts silently.
        issue(1'b1, 12'hADD, 8'hBD, 13'h15AD, 8'h00, 6, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            req_valid          = 1'b0;
            bus_if.slave_ready = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_outputs", out_vec(), 32'd0);
        @(negedge clk);
        reset              = 1'b1;
        bus_if.slave_ready = 1'b0;

        // Fresh write after reset restarts from bit 0.
        issue(1'b1, 12'hADD, 8'hBD, 13'h15AD, 8'h00, NBITS, 1'b1);
        send(0, 0, 0);
        ack();

`ifdef MASTER_TIMEOUT_EN
        // Write never acknowledged: err 16 cycles after the last bit, no done.
        issue(1'b1, 12'h0AA, 8'h55, 13'h0AAA, 8'h00, NBITS, 1'b0);
        exp_resp.push_back(resp_t'{1'b0, 1'b0, 1'b1, 8'h00});
        err_cyc = -1;
        send(0, 0, 0);
        for (int k = 0; k < 40 && err_cyc < 0; k++) begin
            @(posedge clk);
            #2;
        end
        check("tmo_err_seen", {31'd0, err_cyc >= 0}, 32'd1);
        check("tmo_delay", err_cyc - mv_last, 16);
        check("tmo_enables_cleared", {30'd0, bus_if.write_en, done}, 32'd0);
        @(negedge clk);
        check("tmo_back_idle", {31'd0, req_ready}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        check("bits_left", exp_bits.size(), 32'd0);
        check("resp_left", exp_resp.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
